// File: rtl/ula_ops_seq.sv
// Multi-cycle ULA operand/op block with valid/ready handshakes and an iterative shift-add multiplier.
// Define ULA_DIV_EN to add the restoring divider for DIV/MOD; otherwise those opcodes are illegal.
module ula_ops_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int ULA_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] IN_ARG,
    input  logic [ULA_WIDTH-1:0]  IN_TOS,
    input  logic [ADDR_WIDTH-1:0] IN_PC,
    input  logic [ADDR_WIDTH-1:0] IN_JUMP,
    input  logic [1:0]            SEL_OP1,
    input  logic [1:0]            SEL_OP2,
    input  logic [3:0]            SEL_ULA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [ULA_WIDTH-1:0]  ULA_OUT,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  REG_COMP_OUT,
    output logic                  REG_OVERFLOW_OUT
);

    localparam int W     = ULA_WIDTH;
    localparam int CNT_W = $clog2(ULA_WIDTH + 1);
    localparam logic [W-1:0]     W_VAL    = W'(ULA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ULA_WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_LT  = 4'd7;
    localparam logic [3:0] OP_EQ  = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_DIV = 4'd10;
    localparam logic [3:0] OP_MOD = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cmp;
        logic         ovf;
    } alu_t;

    // Two's-complement overflow of s = a + b (callers pass ~b for subtraction).
    function automatic logic add_ovf(input logic signed [W-1:0] a,
                                     input logic signed [W-1:0] b,
                                     input logic signed [W-1:0] s);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    function automatic alu_t alu_single(input logic [3:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
        alu_t r;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic [W-1:0] s;
        r  = '0;
        sa = $signed(a);
        sb = $signed(b);
        s  = '0;
        case (op)
            OP_ADD: begin
                s     = a + b;
                r.res = s;
                r.ovf = add_ovf(sa, sb, $signed(s));
            end
            OP_SUB: begin
                s     = a - b;
                r.res = s;
                r.ovf = add_ovf(sa, ~sb, $signed(s));
            end
            OP_AND: r.res = a & b;
            OP_OR:  r.res = a | b;
            OP_XOR: r.res = a ^ b;
            OP_SHL: r.res = (b >= W_VAL) ? '0 : (a << b);
            OP_SHR: r.res = (b >= W_VAL) ? '0 : (a >> b);
            OP_LT:  r.res = W'(sa < sb);
            OP_EQ:  r.res = W'(a == b);
`ifdef ULA_DIV_EN
            // Only the divide-by-zero case resolves in a single cycle.
            OP_DIV: begin
                r.res = '1;
                r.ovf = 1'b1;
            end
            OP_MOD: begin
                r.res = a;
                r.ovf = 1'b1;
            end
`endif
            default: begin
                r.res = '0;
                r.ovf = 1'b1;
            end
        endcase
        if (op == OP_LT || op == OP_EQ)
            r.cmp = r.res[0];
        else if (op <= OP_SHR)
            r.cmp = (r.res == '0);
        else
            r.cmp = 1'b0;
        return r;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_r;
    logic [W-1:0]     hi;
    logic [W-1:0]     lo;
    logic [W-1:0]     b_r;

    logic [W-1:0] op1;
    logic [W-1:0] op2;
    alu_t         alu;
    logic         is_multi;
    logic [W:0]   mul_sum;
    logic [W-1:0] next_hi;
    logic [W-1:0] next_lo;
    logic [W-1:0] fin_res;
    logic         fin_ovf;
`ifdef ULA_DIV_EN
    logic [W:0]   rem_sh;
    logic [W:0]   diff;
`endif

    always_comb begin
        case (SEL_OP1)
            2'd0:    op1 = W'(IN_ARG);
            2'd1:    op1 = IN_TOS;
            2'd2:    op1 = W'(IN_PC);
            default: op1 = W'(IN_JUMP);
        endcase
        case (SEL_OP2)
            2'd0:    op2 = W'(IN_ARG);
            2'd1:    op2 = IN_TOS;
            2'd2:    op2 = W'(IN_PC);
            default: op2 = W'(IN_JUMP);
        endcase
        alu      = alu_single(SEL_ULA, op1, op2);
        is_multi = (SEL_ULA == OP_MUL);
`ifdef ULA_DIV_EN
        if ((SEL_ULA == OP_DIV || SEL_ULA == OP_MOD) && op2 != '0)
            is_multi = 1'b1;
`endif
    end

    // One iteration: {hi,lo} holds partial product (MUL) or remainder/quotient (DIV/MOD).
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
        next_hi = mul_sum[W:1];
        next_lo = {mul_sum[0], lo[W-1:1]};
`ifdef ULA_DIV_EN
        rem_sh = {hi, lo[W-1]};
        diff   = rem_sh - {1'b0, b_r};
        if (op_r != OP_MUL) begin
            if (!diff[W]) begin
                next_hi = diff[W-1:0];
                next_lo = {lo[W-2:0], 1'b1};
            end else begin
                next_hi = rem_sh[W-1:0];
                next_lo = {lo[W-2:0], 1'b0};
            end
        end
`endif
        fin_res = (op_r == OP_MOD) ? next_hi : next_lo;
        fin_ovf = (op_r == OP_MUL) && (next_hi != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            IN_READY         <= 1'b1;
            OUT_VALID        <= 1'b0;
            ULA_OUT          <= '0;
            REG_COMP_OUT     <= 1'b0;
            REG_OVERFLOW_OUT <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (IN_VALID && IN_READY) begin
                        IN_READY <= 1'b0;
                        if (is_multi) begin
                            state <= S_EXEC;
                            cnt   <= '0;
                            op_r  <= SEL_ULA;
                            hi    <= '0;
                            lo    <= op1;
                            b_r   <= op2;
                        end else begin
                            state            <= S_DONE;
                            OUT_VALID        <= 1'b1;
                            ULA_OUT          <= alu.res;
                            REG_COMP_OUT     <= alu.cmp;
                            REG_OVERFLOW_OUT <= alu.ovf;
                        end
                    end
                end
                S_EXEC: begin
                    hi  <= next_hi;
                    lo  <= next_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state            <= S_DONE;
                        OUT_VALID        <= 1'b1;
                        ULA_OUT          <= fin_res;
                        REG_COMP_OUT     <= (fin_res == '0);
                        REG_OVERFLOW_OUT <= fin_ovf;
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        state     <= S_IDLE;
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
